shifter_pipe_n: RTL and testbench
=================================

Name: shifter_pipe_n

Overview:
- Parametrised, pipelined barrel shifter. Successor to the fixed 32-bit combinational shifter.
- Shift mode is a per-transaction runtime input, not an elaboration parameter.
- Adds correct arithmetic-right and rotate operations, valid/ready handshake, tag pass-through and full-pipeline backpressure.
- Sits between the ALU operand mux and the writeback mux in multi-cycle/pipelined datapaths.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, at least 4.
- LOG2W, 5, shift-amount width and pipeline depth; must equal log2(WIDTH), otherwise elaboration error.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  LOG2W  shift amount, unsigned, 0..WIDTH-1.
- in_op  input  3  mode: 0 SLL, 1 ROL, 2 SRL, 3 SRA, 4 ROR, 5-7 pass-through.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the operation in out_data.

Behaviour:
- Pipeline: LOG2W register stages. Stage k conditionally shifts/rotates by 2^k when in_amt[k] is set.
- Each stage carries valid, data, the remaining amount bits, op and tag.
- Global stall: advance = !out_valid | out_ready. When advance=1 all stages shift together; otherwise every stage holds.
- in_ready = advance, combinational; no combinational path from in_valid to in_ready.
- Transfer on in_valid & in_ready. A cycle with in_valid=0 and advance=1 inserts a bubble (valid=0) into stage 0.
- Latency: exactly LOG2W cycles from accept edge to out_valid when unstalled. Throughput: one op per cycle.
- Ordering: strictly in order; no reordering, drop or duplication.
- Hold rule: while out_valid=1 and out_ready=0, out_data and out_tag are stable.
- SLL: vacated LSBs filled with 0.
- SRL: vacated MSBs filled with 0.
- SRA: vacated MSBs filled with in_data[WIDTH-1]; the sign is sampled at accept.
- ROL/ROR: bits wrap modulo WIDTH.
- Pass-through (op 5-7): result = in_data regardless of amount.
- Amount 0: result = in_data for every op.
- Reset: async assertion clears all stage valids, so out_valid=0, out_data=0 and out_tag=0 immediately. Any in-flight operations are discarded and never emitted.
- Reset release: in_ready=1 on the first clk after deassertion.
- Simultaneous events: when the output is accepted while a new op is accepted in the same cycle, both transfers happen; the pipeline stays full.

Optional Feature:
- Macro: SHIFTER_PIPE_ZERO_FLAG_EN.
- With macro defined: add output port out_zero (1 bit), registered in the final stage, =1 iff out_data==0. It is valid with out_valid, follows the same hold rule, and resets to 0.
- Without macro: port absent; no extra logic.

Test Plan (WIDTH=32):
- SLL/SRL/SRA: SLL 0x00000001 amt 31 -> 0x80000000 exactly 5 cycles after accept. SRL 0x80000000 amt 4 -> 0x08000000. SRA 0x80000000 amt 4 -> 0xF8000000. SRA 0x7FFFFFFF amt 31 -> 0x00000000.
- Rotates: ROL 0x80000001 amt 1 -> 0x00000003. ROR 0x00000001 amt 1 -> 0x80000000. ROR 0x12345678 amt 0 -> 0x12345678.
- Pass-through: op 5 with 0xDEADBEEF amt 7 -> 0xDEADBEEF.
- Backpressure: 8 back-to-back ops with tags 0..7; out_ready=0 on cycles 6-9.
  - in_ready drops while out_valid=1 and out_ready=0.
  - out_data and out_tag stay stable throughout.
  - All 8 results emerge in tag order with no loss.
- Bubbles: alternating in_valid 1/0 -> out_valid alternates, each result 5 cycles after its accept.
- Reset mid-flight: 3 ops in the pipe, rst_n pulsed low -> out_valid=0 immediately; none of the 3 ever emitted; in_ready=1 on the first clk after release.
  - With SHIFTER_PIPE_ZERO_FLAG_EN: SLL 0x00000001 amt 31 -> out_zero=0; SRL 0x00000001 amt 1 -> out_zero=1.

Source files
------------

// File: rtl/shifter_pipe_n.sv
// Pipelined barrel shifter: one conditional 2^k shift/rotate per register stage, valid/ready with global stall.
// Optional SHIFTER_PIPE_ZERO_FLAG_EN adds a registered out_zero flag for the result in out_data.
module shifter_pipe_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2W = 5,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || LOG2W != $clog2(WIDTH)) begin : g_bad_params
    $error("shifter_pipe_n: WIDTH must be a power of two >= 4 and LOG2W must equal log2(WIDTH)");
  end

  localparam int unsigned LAST = LOG2W - 1;

  // Stage registers; amount/op are only needed by downstream stages, so the last stage drops them.
  logic             valid_q [LOG2W];
  logic [WIDTH-1:0] data_q  [LOG2W];
  logic [TAG_W-1:0] tag_q   [LOG2W];
  logic [LOG2W-1:0] amt_q   [LOG2W-1];
  logic [2:0]       op_q    [LOG2W-1];

  logic             src_valid [LOG2W];
  logic [WIDTH-1:0] src_data  [LOG2W];
  logic [TAG_W-1:0] src_tag   [LOG2W];
  logic [LOG2W-1:0] src_amt   [LOG2W];
  logic [2:0]       src_op    [LOG2W];
  logic [WIDTH-1:0] nxt_data  [LOG2W];

  logic advance;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                            input logic en, input int unsigned k);
    int unsigned s;
    s = 32'd1 << k;
    step = d;
    if (en) begin
      case (op)
        3'd0:    step = d << s;
        3'd1:    step = (d << s) | (d >> (WIDTH - s));
        3'd2:    step = d >> s;
        3'd3:    step = $signed(d) >>> s;
        3'd4:    step = (d >> s) | (d << (WIDTH - s));
        default: step = d;
      endcase
    end
  endfunction

  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_tag[0]   = in_tag;
    src_amt[0]   = in_amt;
    src_op[0]    = in_op;
    for (int unsigned k = 1; k < LOG2W; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_tag[k]   = tag_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_op[k]    = op_q[k-1];
    end
    for (int unsigned k = 0; k < LOG2W; k++) begin
      nxt_data[k] = step(src_data[k], src_op[k], src_amt[k][k], k);
    end
  end

  // One stall signal for the whole pipe: bubbles are not squeezed out, which keeps the output hold simple.
  assign advance   = !valid_q[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_tag   = tag_q[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LOG2W; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        tag_q[k]   <= '0;
      end
      for (int unsigned k = 0; k < LOG2W - 1; k++) begin
        amt_q[k] <= '0;
        op_q[k]  <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < LOG2W; k++) begin
        valid_q[k] <= src_valid[k];
        data_q[k]  <= nxt_data[k];
        tag_q[k]   <= src_tag[k];
      end
      for (int unsigned k = 0; k < LOG2W - 1; k++) begin
        amt_q[k] <= src_amt[k];
        op_q[k]  <= src_op[k];
      end
    end
  end

`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b0;
    end else if (advance) begin
      out_zero <= (nxt_data[LAST] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_shifter_pipe_n.sv
// Directed bench for shifter_pipe_n (WIDTH=32): scoreboard queue filled at accept, drained by an output monitor.
module tb_shifter_pipe_n;
  localparam int unsigned W = 32;
  localparam int unsigned L = 5;
  localparam int unsigned T = 4;

  typedef struct {
    logic [T-1:0] tag;
    logic [W-1:0] data;
    int           acc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [L-1:0] in_amt = '0;
  logic [2:0]   in_op = '0;
  logic [T-1:0] in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [T-1:0] out_tag;
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   post_rst_out = 0;
  bit   head_seen = 0;
  bit   hold_prev = 0;
  logic [W-1:0] prev_d;
  logic [T-1:0] prev_t;
  exp_t q[$];

  shifter_pipe_n #(.WIDTH(W), .LOG2W(L), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bit-level reference: each result bit picks its source bit directly.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [L-1:0] a, input logic [2:0] op);
    logic [W-1:0] r;
    logic [L-1:0] idx;
    int n;
    n = int'(a);
    for (int i = 0; i < 32; i++) begin
      case (op)
        3'd0: begin idx = 5'(i - n);      r[i] = (i >= n) ? d[idx] : 1'b0; end
        3'd1: begin idx = 5'(i - n + 32); r[i] = d[idx]; end
        3'd2: begin idx = 5'(i + n);      r[i] = (i + n < 32) ? d[idx] : 1'b0; end
        3'd3: begin idx = 5'(i + n);      r[i] = (i + n < 32) ? d[idx] : d[31]; end
        3'd4: begin idx = 5'(i + n);      r[i] = d[idx]; end
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Output monitor, sampled 2 time units after the falling edge so all driver updates have settled.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (hold_prev) begin
        total++;
        assert (out_valid === 1'b1 && out_data === prev_d && out_tag === prev_t)
          else begin bad++; $error("FAIL hold: valid=%b data=%h tag=%h, expected valid=1 data=%h tag=%h", out_valid, out_data, out_tag, prev_d, prev_t); end
      end
      total++;
      assert (in_ready === !(out_valid && !out_ready))
        else begin bad++; $error("FAIL in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready); end
      if (out_valid) begin
        post_rst_out++;
        total++;
        assert (q.size() != 0)
          else begin bad++; $error("FAIL spurious: out_valid with tag=%h data=%h, expected no output", out_tag, out_data); end
        if (q.size() != 0) begin
          if (!head_seen) begin
            head_seen = 1;
            if (q[0].lat) begin
              total++;
              assert (cyc === q[0].acc + int'(L) - 1)
                else begin bad++; $error("FAIL latency tag=%0d: appeared after edge %0d, expected edge %0d", q[0].tag, cyc, q[0].acc + int'(L) - 1); end
            end
          end
          if (out_ready) begin
            e = q.pop_front();
            head_seen = 0;
            total++;
            assert (out_data === e.data && out_tag === e.tag)
              else begin bad++; $error("FAIL result: data=%h tag=%h, expected data=%h tag=%h", out_data, out_tag, e.data, e.tag); end
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
            total++;
            assert (out_zero === (e.data == '0))
              else begin bad++; $error("FAIL zero_flag tag=%0d: got %b, expected %b", e.tag, out_zero, (e.data == '0)); end
`endif
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_t = out_tag;
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input logic [L-1:0] a,
                      input logic [T-1:0] tag, input logic [W-1:0] exp, input bit lat);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = a; in_tag = tag;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    assert (in_ready === 1'b1)
      else begin bad++; $error("FAIL accept_timeout tag=%0d: in_ready=%b, expected 1", tag, in_ready); end
    if (in_ready) q.push_back('{tag, exp, cyc + 1, lat});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    assert (q.size() == 0)
      else begin bad++; $error("FAIL drain: %0d results outstanding, expected 0", q.size()); end
  endtask

  initial begin
    #1;
    total++;
    assert (out_valid === 1'b0 && out_data === '0 && out_tag === '0)
      else begin bad++; $error("FAIL reset_state: valid=%b data=%h tag=%h, expected 0/0/0", out_valid, out_data, out_tag); end
`ifdef SHIFTER_PIPE_ZERO_FLAG_EN
    total++;
    assert (out_zero === 1'b0)
      else begin bad++; $error("FAIL reset_zero: got %b, expected 0", out_zero); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed single ops with latency checks.
    send(3'd0, 32'h0000_0001, 5'd31, 4'd1, 32'h8000_0000, 1); drain();
    send(3'd2, 32'h8000_0000, 5'd4,  4'd2, 32'h0800_0000, 1); drain();
    send(3'd3, 32'h8000_0000, 5'd4,  4'd3, 32'hF800_0000, 1); drain();
    send(3'd3, 32'h7FFF_FFFF, 5'd31, 4'd4, 32'h0000_0000, 1); drain();
    send(3'd1, 32'h8000_0001, 5'd1,  4'd5, 32'h0000_0003, 1); drain();
    send(3'd4, 32'h0000_0001, 5'd1,  4'd6, 32'h8000_0000, 1); drain();
    send(3'd4, 32'h1234_5678, 5'd0,  4'd7, 32'h1234_5678, 1); drain();
    send(3'd5, 32'hDEAD_BEEF, 5'd7,  4'd8, 32'hDEAD_BEEF, 1); drain();
    send(3'd2, 32'h0000_0001, 5'd1,  4'd9, 32'h0000_0000, 1); drain();

    // Back-to-back unstalled ops across every mode.
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 32'hC3A5_0F71 ^ 32'(i * 32'h1111_0000), 5'(i * 5 + 3), 4'(i), model(32'hC3A5_0F71 ^ 32'(i * 32'h1111_0000), 5'(i * 5 + 3), 3'(i)), 1);
    end
    drain();

    // Backpressure: out_ready low on relative cycles 6-9.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(3'(i % 5), 32'hA5A5_1234 + 32'(i), 5'(i * 3 + 1), 4'(i), model(32'hA5A5_1234 + 32'(i), 5'(i * 3 + 1), 3'(i % 5)), 0);
        end
        drain();
      end
      begin
        int b;
        b = cyc;
        repeat (20) begin
          @(negedge clk);
          out_ready = !((cyc - b) >= 6 && (cyc - b) <= 9);
        end
        out_ready = 1'b1;
      end
    join

    // Bubbles: alternating valid, each result checked for latency.
    for (int i = 0; i < 4; i++) begin
      send(3'd3, 32'h9000_0000 >> i, 5'(i + 1), 4'(i + 10), model(32'h9000_0000 >> i, 5'(i + 1), 3'd3), 1);
      idle(1);
    end
    drain();

    // Reset mid-flight with the oldest op stalled at the output.
    begin
      int n;
      send(3'd0, 32'h0000_00FF, 5'd2, 4'hA, 32'h0000_03FC, 0);
      send(3'd2, 32'hFF00_0000, 5'd3, 4'hB, 32'h1FE0_0000, 0);
      send(3'd1, 32'h0F00_000F, 5'd8, 4'hC, 32'h0000_0F0F, 0);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      total++;
      assert (out_valid === 1'b1)
        else begin bad++; $error("FAIL prefill: out_valid=%b, expected 1", out_valid); end
      #3 rst_n = 1'b0;
      #1;
      total++;
      assert (out_valid === 1'b0 && out_data === '0 && out_tag === '0)
        else begin bad++; $error("FAIL async_reset: valid=%b data=%h tag=%h, expected 0/0/0", out_valid, out_data, out_tag); end
      q.delete();
      head_seen = 0;
      hold_prev = 0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      post_rst_out = 0;
      @(posedge clk);
      #1;
      total++;
      assert (in_ready === 1'b1)
        else begin bad++; $error("FAIL ready_after_reset: got %b, expected 1", in_ready); end
      repeat (10) @(negedge clk);
      total++;
      assert (post_rst_out == 0)
        else begin bad++; $error("FAIL discarded: %0d outputs after reset, expected 0", post_rst_out); end
    end

    send(3'd4, 32'h0000_00F0, 5'd4, 4'hF, 32'h0000_000F, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
